// File: rtl/adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit adder cells used by the serial adder: halfadder and full_adder (two halfadders + OR).
module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  halfadder u_ha0 (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  halfadder u_ha1 (
    .a (s1),
    .b (cin),
    .s (s),
    .c (c2)
  );

  assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: WIDTH cycles per add, LSB first, done pulses one cycle after the last bit.
// SERIAL_ADDER_OVF_EN adds a held two's-complement overflow output (ovf).
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             cout_q;
  logic             fa_s;
  logic             fa_c;
  logic             load;
  logic             last_bit;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign last_bit = (cnt == LAST);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operands shift right so bit 0 always feeds the adder; sum bits enter at the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
      carry  <= fa_c;
      if (last_bit) begin
        cout_q <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
        // On the last bit, a_sh[0]/b_sh[0] are the original operand sign bits.
        ovf_q  <= (a_sh[0] == b_sh[0]) && (fa_s != a_sh[0]);
`endif
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign sum  = sum_sh;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8); ovf checks compile in with SERIAL_ADDER_OVF_EN.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Returns 1ns after the accepting edge, start already dropped.
  task automatic pulse_start(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen, bounded by limit.
  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < limit);
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
  endtask

  task automatic test_reset;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset_sum: got %h expected 00", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b expected 0", cout); end
`ifdef SERIAL_ADDER_OVF_EN
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero;
    int n;
    pulse_start(8'h00, 8'h00, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy: got %b expected 1", busy); end
    wait_done(20, n);
    total++; if (n !== 8) begin bad++; $display("FAIL zero_latency: got %0d expected 8", n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_done: got %b expected 0", busy); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL zero_sum: got %h expected 00", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL zero_cout: got %b expected 0", cout); end
`ifdef SERIAL_ADDER_OVF_EN
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL zero_ovf: got %b expected 0", ovf); end
`endif
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_width: got %b expected 0", done); end
  endtask

  task automatic test_carry;
    int n;
    pulse_start(8'hFF, 8'h01, 1'b0);
    wait_done(20, n);
    total++; if (n !== 8) begin bad++; $display("FAIL carry_latency: got %0d expected 8", n); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL carry_sum: got %h expected 00", sum); end
    total++; if (cout !== 1'b1) begin bad++; $display("FAIL carry_cout: got %b expected 1", cout); end
`ifdef SERIAL_ADDER_OVF_EN
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL carry_ovf: got %b expected 0", ovf); end
`endif
    repeat (3) @(posedge clk);
    #1;
    total++; if (sum !== 8'h00 || cout !== 1'b1) begin bad++; $display("FAIL carry_hold: got %b/%h expected 1/00", cout, sum); end

    pulse_start(8'h7F, 8'h01, 1'b0);
    wait_done(20, n);
    total++; if (n !== 8) begin bad++; $display("FAIL ovf_latency: got %0d expected 8", n); end
    total++; if (sum !== 8'h80) begin bad++; $display("FAIL ovf_sum: got %h expected 80", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL ovf_cout: got %b expected 0", cout); end
`ifdef SERIAL_ADDER_OVF_EN
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
`endif
  endtask

  task automatic test_ignore_start;
    int n;
    int pulses;
    pulse_start(8'h35, 8'h4A, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ignore_busy: got %b expected 1", busy); end
    wait_done(20, n);
    total++; if (n !== 5) begin bad++; $display("FAIL ignore_latency: got %0d expected 5", n); end
    total++; if (sum !== 8'h80) begin bad++; $display("FAIL ignore_sum: got %h expected 80", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL ignore_cout: got %b expected 0", cout); end
`ifdef SERIAL_ADDER_OVF_EN
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ignore_ovf: got %b expected 1", ovf); end
`endif
    count_done(10, pulses);
    total++; if (pulses !== 0) begin bad++; $display("FAIL ignore_single_done: got %0d extra pulses expected 0", pulses); end
  endtask

  task automatic test_reset_mid;
    int n;
    pulse_start(8'h55, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL abort_sum: got %h expected 00", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL abort_cout: got %b expected 0", cout); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_hold: got done=%b busy=%b expected 0/0", done, busy); end
    @(negedge clk);
    rst = 1'b0;
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL post_reset_accept: got %b expected 1", busy); end
    wait_done(20, n);
    total++; if (n !== 8) begin bad++; $display("FAIL post_reset_latency: got %0d expected 8", n); end
    total++; if (sum !== 8'h02 || cout !== 1'b0) begin bad++; $display("FAIL post_reset_sum: got %b/%h expected 0/02", cout, sum); end
  endtask

  task automatic test_back_to_back;
    int n;
    pulse_start(8'h10, 8'h20, 1'b0);
    wait_done(20, n);
    total++; if (n !== 8) begin bad++; $display("FAIL b2b_first_latency: got %0d expected 8", n); end
    total++; if (sum !== 8'h30 || cout !== 1'b0) begin bad++; $display("FAIL b2b_first_sum: got %b/%h expected 0/30", cout, sum); end
    pulse_start(8'h80, 8'h80, 1'b0);
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL b2b_restart: got busy=%b done=%b expected 1/0", busy, done); end
    wait_done(20, n);
    total++; if (n !== 8) begin bad++; $display("FAIL b2b_second_latency: got %0d expected 8", n); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL b2b_second_sum: got %h expected 00", sum); end
    total++; if (cout !== 1'b1) begin bad++; $display("FAIL b2b_second_cout: got %b expected 1", cout); end
`ifdef SERIAL_ADDER_OVF_EN
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL b2b_second_ovf: got %b expected 1", ovf); end
`endif
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    cin   = 1'b0;
    test_reset;
    test_zero;
    test_carry;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, is the operand and sum width in bits. WIDTH SHALL be at least 2.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port start, input, 1 bit: request to begin an addition.
REQ-005 Ports a and b, inputs, WIDTH bits each: the two operands.
REQ-006 Port cin, input, 1 bit: carry-in.
REQ-007 Port busy, output, 1 bit: high while the addition is in progress.
REQ-008 Port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-009 Port sum, output, WIDTH bits: the result.
REQ-010 Port cout, output, 1 bit: carry-out of the MSB.
REQ-011 Port ovf, output, 1 bit: two's-complement overflow; present only under SERIAL_ADDER_OVF_EN.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE.
- IDLE -> SHIFT on start=1.
- SHIFT -> DONE after WIDTH bit-cycles.
- DONE -> SHIFT on start=1, otherwise DONE -> IDLE.
REQ-013 Accepting start (in IDLE or DONE) SHALL latch a, b and cin into internal registers, clear the bit counter and enter SHIFT.
REQ-014 Each SHIFT cycle SHALL add one bit pair, LSB first, plus the carry flop, using one full adder.
- The sum bit SHALL shift into the MSB of the sum register.
- The new carry SHALL be stored in the carry flop.
REQ-015 Latency: if start is accepted at edge k, the WIDTH bits SHALL be processed at edges k+1 through k+WIDTH. done SHALL be 1 for exactly the cycle following edge k+WIDTH.
REQ-016 busy SHALL be 1 exactly while in SHIFT.
REQ-017 sum and cout SHALL equal {cout,sum} = a + b + cin (unsigned, WIDTH+1 bits) while done=1. They SHALL hold that value until the next start is accepted.
REQ-018 start while in SHIFT SHALL be ignored. Operand changes after acceptance SHALL NOT affect the result.
REQ-019 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap within one operation.
REQ-020 start=1 in the DONE cycle SHALL begin a new operation with no idle cycle (back-to-back). done SHALL still pulse for the completed result.

Reset
REQ-021 rst=1 SHALL immediately clear the following, regardless of clock: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and counter, carry and operand registers to 0.
REQ-022 Reset asserted mid-operation SHALL abort the addition; done SHALL NOT pulse for it.
REQ-023 After rst deasserts, the first start SHALL be honoured at the first rising clk edge.

Configuration
REQ-024 Macro SERIAL_ADDER_OVF_EN controls the ovf output.
- Defined: port ovf exists. At completion, ovf = (a[MSB] == b[MSB]) AND (sum[MSB] != a[MSB]). It is held alongside sum.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Structure
REQ-025 Package adder_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-026 The one-bit add SHALL be a sub-module full_adder (ports a, b, cin, s, cout), built from two halfadder instances and an OR gate.

Verification (WIDTH=8, SERIAL_ADDER_OVF_EN defined)
REQ-027 The bench SHALL cover these directed scenarios:
- a=8'h00, b=8'h00, cin=0, start 1 cycle -> done 8 cycles later, sum=8'h00, cout=0, ovf=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0; a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
- a=8'h35, b=8'h4A, cin=1, then start re-pulsed and a/b changed at SHIFT cycle 3 -> single done, sum=8'h80, cout=0.
- rst pulsed at SHIFT cycle 4 -> busy=0 and sum=0 at once, no done pulse; the next start with 8'h01+8'h01 -> sum=8'h02.
- start held in the DONE cycle with 8'h80+8'h80 after 8'h10+8'h20 -> first done gives sum=8'h30; second done, exactly 8 cycles later, gives sum=8'h00, cout=1, ovf=1.
- Rebuild without SERIAL_ADDER_OVF_EN and rerun all scenarios excluding ovf -> identical sum, cout and done timing.
